cgra_power_sequencer: RTL and testbench



---
 rtl/cgra_power_sequencer_pkg.sv | 27 ++
 rtl/cgra_pwr_ack_sync.sv | 26 ++
 rtl/cgra_power_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_cgra_power_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cgra_power_sequencer_pkg.sv
// Shared types and default timing constants for the CGRA domain-0 power sequencer.
package cgra_power_sequencer_pkg;

    typedef enum logic [3:0] {
        ON,
        ISO_DN,
        RST_DN,
        SW_OFF,
        OFF,
        SW_ON,
        RST_UP,
        ISO_UP,
        ERR
    } pwr_state_e;

    localparam int unsigned ISO_CYCLES_DEF  = 4;
    localparam int unsigned RST_CYCLES_DEF  = 8;
    localparam int unsigned ACK_TIMEOUT_DEF = 1024;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cgra_pwr_ack_sync.sv
// Two-flop synchroniser for the asynchronous powergate acknowledge.
module cgra_pwr_ack_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cgra_power_sequencer.sv
// Power-down/power-up sequencer for the CGRA external domain (switch, isolation, reset, retention).
// Memory retention control is built only when CGRA_PWR_RETENTION_EN is defined.
module cgra_power_sequencer
    import cgra_power_sequencer_pkg::*;
#(
    parameter int unsigned ISO_CYCLES  = ISO_CYCLES_DEF,
    parameter int unsigned RST_CYCLES  = RST_CYCLES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwr_on_req_i,
    input  logic pwr_off_req_i,
    input  logic retain_i,
    input  logic switch_ack_i,
    output logic switch_o,
    output logic iso_o,
    output logic logic_rst_no,
    output logic set_retentive_o,
    output logic busy_o,
    output logic powered_o,
    output logic done_o,
    output logic err_o
);

    localparam int unsigned MAX_CYC = max3(ISO_CYCLES, RST_CYCLES, ACK_TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             switch_q, switch_d;
    logic             iso_q, iso_d;
    logic             rstn_q, rstn_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ack_s;
    logic             on_req, off_req;

    cgra_pwr_ack_sync #(.RST_VAL(1'b1)) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (switch_ack_i),
        .q_o   (ack_s)
    );

    // Simultaneous on/off requests cancel each other out.
    assign on_req  = pwr_on_req_i & ~pwr_off_req_i;
    assign off_req = pwr_off_req_i & ~pwr_on_req_i;

    always_comb begin
        state_d  = state_q;
        switch_d = switch_q;
        iso_d    = iso_q;
        rstn_d   = rstn_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            ON: begin
                if (off_req)     state_d = ISO_DN;
                else if (on_req) done_d  = 1'b1;
            end
            ISO_DN: if (cnt_q == ISO_LAST) state_d = RST_DN;
            RST_DN: state_d = SW_OFF;
            SW_OFF: begin
                if (!ack_s) begin
                    state_d = OFF;
                    done_d  = 1'b1;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = ERR;
                end
            end
            OFF: begin
                if (on_req)       state_d = SW_ON;
                else if (off_req) done_d  = 1'b1;
            end
            SW_ON: begin
                if (ack_s)                  state_d = RST_UP;
                else if (cnt_q == ACK_LAST) state_d = ERR;
            end
            RST_UP: if (cnt_q == RST_LAST) state_d = ISO_UP;
            ISO_UP: begin
                if (cnt_q == ISO_LAST) begin
                    state_d = ON;
                    done_d  = 1'b1;
                end
            end
            ERR: begin
                if (on_req) begin
                    state_d = SW_ON;
                    err_d   = 1'b0;
                end else if (off_req) begin
                    state_d = ISO_DN;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ON;
        endcase

        // Pad outputs only change on state entry, so ERR naturally holds them.
        if (state_d != state_q) begin
            case (state_d)
                ON:     begin switch_d = 1'b1; iso_d = 1'b0; rstn_d = 1'b1; end
                ISO_DN: iso_d  = 1'b1;
                RST_DN: rstn_d = 1'b0;
                SW_OFF: switch_d = 1'b0;
                OFF:    begin switch_d = 1'b0; iso_d = 1'b1; rstn_d = 1'b0; end
                SW_ON:  switch_d = 1'b1;
                RST_UP: begin iso_d = 1'b1; rstn_d = 1'b0; end
                ISO_UP: rstn_d = 1'b1;
                ERR:    err_d  = 1'b1;
                default: ;
            endcase
        end

        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
        else                     cnt_d = cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ON;
            cnt_q    <= '0;
            switch_q <= 1'b1;
            iso_q    <= 1'b0;
            rstn_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            switch_q <= switch_d;
            iso_q    <= iso_d;
            rstn_q   <= rstn_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef CGRA_PWR_RETENTION_EN
    logic retain_q, retain_d;
    logic ret_q, ret_d;

    // Retain choice is captured with the off request that starts the power-down.
    always_comb begin
        retain_d = retain_q;
        ret_d    = ret_q;
        if (state_d != state_q) begin
            if (state_d == ISO_DN)                        retain_d = retain_i;
            if (state_d == RST_DN)                        ret_d    = retain_q;
            else if (state_d == SW_ON || state_d == ON)   ret_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retain_q <= 1'b0;
            ret_q    <= 1'b0;
        end else begin
            retain_q <= retain_d;
            ret_q    <= ret_d;
        end
    end

    assign set_retentive_o = ret_q;
`else
    logic unused_retain;
    assign unused_retain   = retain_i;
    assign set_retentive_o = 1'b0;
`endif

    assign switch_o     = switch_q;
    assign iso_o        = iso_q;
    assign logic_rst_no = rstn_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = !(state_q == ON || state_q == OFF || state_q == ERR);
    assign powered_o    = (state_q == ON);

endmodule

// File: tb/tb_cgra_power_sequencer.sv
// Directed vector bench for cgra_power_sequencer; follows CGRA_PWR_RETENTION_EN for retention expectations.
module tb_cgra_power_sequencer;

    // Output vector bit order: {switch, iso, rst_n, retentive, busy, powered, done, err}
    localparam logic [7:0] E_ON     = 8'b1010_0100;
    localparam logic [7:0] E_ISO_DN = 8'b1110_1000;
    localparam logic [7:0] E_RST_DN = 8'b1100_1000;
    localparam logic [7:0] E_SW_OFF = 8'b0100_1000;
    localparam logic [7:0] E_OFF    = 8'b0100_0000;
    localparam logic [7:0] E_SW_ON  = 8'b1100_1000;
    localparam logic [7:0] E_RST_UP = 8'b1100_1000;
    localparam logic [7:0] E_ISO_UP = 8'b1110_1000;
    localparam logic [7:0] E_ERR    = 8'b0100_0001;
    localparam logic [7:0] DONE     = 8'b0000_0010;
`ifdef CGRA_PWR_RETENTION_EN
    localparam logic [7:0] RET = 8'b0001_0000;
`else
    localparam logic [7:0] RET = 8'b0000_0000;
`endif

    typedef struct {
        logic        on;
        logic        off;
        logic        ret;
        int          dly;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic pwr_on_req_i = 1'b0;
    logic pwr_off_req_i = 1'b0;
    logic retain_i = 1'b0;
    logic switch_ack_i;
    logic switch_o, iso_o, logic_rst_no, set_retentive_o, busy_o, powered_o, done_o, err_o;

    logic [15:0] sw_hist = '1;
    int          ack_dly = 3;
    logic        ack_stuck = 1'b0;
    vec_t        vecs[$];
    int          nvec = 0;
    int          nmis = 0;

    always #5 clk = ~clk;

    // Powergate model: ack follows switch_o after ack_dly cycles, or is stuck high.
    always @(posedge clk) sw_hist <= {sw_hist[14:0], switch_o};
    assign switch_ack_i = ack_stuck ? 1'b1 : sw_hist[ack_dly-1];

    cgra_power_sequencer #(
        .ISO_CYCLES  (4),
        .RST_CYCLES  (8),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pwr_on_req_i    (pwr_on_req_i),
        .pwr_off_req_i   (pwr_off_req_i),
        .retain_i        (retain_i),
        .switch_ack_i    (switch_ack_i),
        .switch_o        (switch_o),
        .iso_o           (iso_o),
        .logic_rst_no    (logic_rst_no),
        .set_retentive_o (set_retentive_o),
        .busy_o          (busy_o),
        .powered_o       (powered_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    task automatic add(input logic on, input logic off, input logic ret, input int dly,
                       input logic [7:0] exp, input string name);
        vec_t v;
        v.on = on; v.off = off; v.ret = ret; v.dly = dly; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] exp, input logic [7:0] mask);
        logic [7:0] obs;
        obs = {switch_o, iso_o, logic_rst_no, set_retentive_o, busy_o, powered_o, done_o, err_o};
        nvec++;
        if ((obs & mask) !== (exp & mask)) begin
            nmis++;
            $display("FAIL %s: got %b, expected %b (mask %b)", name, obs, exp, mask);
        end else begin
            $display("ok   %s: %b", name, obs);
        end
    endtask

    task automatic apply(input logic on, input logic off, input logic ret, input logic [7:0] exp,
                         input logic [7:0] mask, input string name);
        @(negedge clk);
        pwr_on_req_i = on; pwr_off_req_i = off; retain_i = ret;
        @(posedge clk); #1;
        pwr_on_req_i = 1'b0; pwr_off_req_i = 1'b0;
        check(name, exp, mask);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;

        // Power-down with retention requested; busy-time requests must be ignored.
        add(0, 1, 1, 3, E_ISO_DN, "pd_iso_c1");
        add(0, 1, 0, 3, E_ISO_DN, "pd_off_ignored");
        add(1, 0, 0, 3, E_ISO_DN, "pd_on_ignored");
        add(0, 0, 0, 3, E_ISO_DN, "pd_iso_c4");
        add(0, 0, 0, 3, E_RST_DN | RET, "pd_rst_c5");
        for (int i = 0; i < 6; i++) add(0, 0, 0, 3, E_SW_OFF | RET, "pd_swoff");
        add(0, 0, 0, 3, E_OFF | RET | DONE, "pd_done_c12");
        add(0, 0, 0, 3, E_OFF | RET, "pd_off");
        add(0, 1, 0, 3, E_OFF | RET | DONE, "off_offreq_done");
        add(0, 0, 0, 3, E_OFF | RET, "off_idle");
        add(1, 1, 0, 3, E_OFF | RET, "off_both_noop");
        // Power-up: ack 5 cycles after switch, 2-cycle sync, 8 reset, 4 isolation cycles.
        add(1, 0, 0, 5, E_SW_ON, "pu_swon_c1");
        for (int i = 0; i < 7; i++) add(0, 0, 0, 5, E_SW_ON, "pu_swon_wait");
        for (int i = 0; i < 8; i++) add(0, 0, 0, 5, E_RST_UP, "pu_rst_held");
        for (int i = 0; i < 4; i++) add(0, 0, 0, 5, E_ISO_UP, "pu_iso_held");
        add(0, 0, 0, 5, E_ON | DONE, "pu_done_c21");
        add(0, 0, 0, 5, E_ON, "pu_on");
        // Request corners in ON.
        add(1, 1, 0, 5, E_ON, "on_both_noop");
        add(1, 0, 0, 5, E_ON | DONE, "on_onreq_done");
        add(0, 0, 0, 5, E_ON, "on_idle");

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", E_ON, 8'hFF);
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            ack_dly = vecs[i].dly;
            apply(vecs[i].on, vecs[i].off, vecs[i].ret, vecs[i].exp, 8'hFF, vecs[i].name);
        end

        // Ack timeout: ack stuck high during SW_OFF, 16 cycles then ERR.
        ack_stuck = 1'b1;
        apply(0, 1, 0, E_ISO_DN, 8'hFF, "to_iso_c1");
        repeat (20) step();
        check("to_swoff_c21", E_SW_OFF, 8'hFF);
        step();
        check("to_err_c22", E_ERR, 8'hFF);
        repeat (3) step();
        check("to_err_hold", E_ERR, 8'hFF);
        ack_stuck = 1'b0;
        apply(0, 1, 0, E_SW_OFF, 8'h4F, "err_offreq_rerun");
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done_o === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            check("rerun_off_done", E_OFF | DONE, 8'hFF);
        end else begin
            nvec++;
            nmis++;
            $display("FAIL rerun_off_done: no done_o within 40 cycles, expected a done pulse");
        end

        // Reset from OFF, then reset in the middle of SW_OFF.
        @(negedge clk);
        rst_i = 1'b1;
        step();
        check("rst_from_off", E_ON, 8'hFF);
        @(negedge clk);
        rst_i = 1'b0;
        ack_stuck = 1'b1;
        apply(0, 1, 0, E_ISO_DN, 8'hFF, "rm_iso_c1");
        repeat (5) step();
        check("rm_swoff_c6", E_SW_OFF, 8'hFF);
        @(negedge clk);
        rst_i = 1'b1;
        step();
        check("rst_mid_swoff", E_ON, 8'hFF);
        @(negedge clk);
        rst_i = 1'b0;
        ack_stuck = 1'b0;
        apply(1, 0, 0, E_ON | DONE, 8'hFF, "post_rst_onreq");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
